// File: rtl/bs_register_gen2_pkg.sv
// Shared definitions for the boundary-scan data register.
// Contents:
//   mode_e     instruction modes seen by the register
//   cnt_width  default width of the shift counter; one bit wider than needed to hold N,
//              so that an over-long shift stays distinguishable from exactly N
package bs_register_gen2_pkg;

    typedef enum logic [1:0] {
        ModeNormal = 2'b00,
        ModeSample = 2'b01,
        ModeExtest = 2'b10,
        ModeIntest = 2'b11
    } mode_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return int'($clog2(n + 1)) + 1;
    endfunction

endpackage

// File: rtl/bs_register_gen2_if.sv
// Bus between the TAP side / pins and the boundary-scan data register.
// Signals:
//   par_in      parallel data from pins/core
//   par_out     parallel data to pins/core
//   shift_in    TDI-side serial input, enters at the MSB cell
//   shift_out   TDO-side serial output, LSB cell of the capture stage
//   mode        instruction mode (mode_e)
//   capture_dr  one-cycle capture enable
//   shift_dr    shift enable, one bit per clock
//   update_dr   one-cycle update enable
//   shift_cnt   bits shifted since the last capture, saturating
//   len_err     the last update saw shift_cnt != N
//   proto_err   sticky: more than one enable was asserted in a single cycle
// Modports: master drives the controls (TAP/bench); slave is the register.
interface bs_register_gen2_if #(
    parameter int unsigned N  = 10,
    parameter int unsigned CW = bs_register_gen2_pkg::cnt_width(N)
) ();

    logic [N-1:0]                par_in;
    logic [N-1:0]                par_out;
    logic                        shift_in;
    logic                        shift_out;
    bs_register_gen2_pkg::mode_e mode;
    logic                        capture_dr;
    logic                        shift_dr;
    logic                        update_dr;
    logic [CW-1:0]               shift_cnt;
    logic                        len_err;
    logic                        proto_err;

    modport master (
        output par_in, shift_in, mode, capture_dr, shift_dr, update_dr,
        input  par_out, shift_out, shift_cnt, len_err, proto_err
    );

    modport slave (
        input  par_in, shift_in, mode, capture_dr, shift_dr, update_dr,
        output par_out, shift_out, shift_cnt, len_err, proto_err
    );

endinterface

// File: rtl/bs_register_gen2_cell.sv
// One boundary-scan cell: a capture/shift flop, an update flop and the parallel output mux.
// Ports:
//   clk_i, rst_ni  test clock, synchronous active-low reset
//   capture_i      load cap_q from par_in_i
//   shift_i        load cap_q from serial_i
//   update_i       load upd_q from cap_q
//   par_in_i       pin/core value of this bit
//   serial_i       serial input from the next-higher cell (or TDI for the MSB)
//   mode_i         instruction mode
//   cap_o          capture stage value (feeds the next-lower cell)
//   par_out_o      parallel output of this bit
// Dir selects the cell type: 1 = output cell (pin side), 0 = input cell (core side).
// The enables are expected to be mutually exclusive; the parent resolves priority.
module bs_register_gen2_cell
    import bs_register_gen2_pkg::*;
#(
    parameter bit Dir    = 1'b1,
    parameter bit RstVal = 1'b0
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  capture_i,
    input  logic  shift_i,
    input  logic  update_i,
    input  logic  par_in_i,
    input  logic  serial_i,
    input  mode_e mode_i,
    output logic  cap_o,
    output logic  par_out_o
);

    logic cap_q, cap_d;
    logic upd_q, upd_d;

    always_comb begin
        cap_d = cap_q;
        upd_d = upd_q;
        if (capture_i) begin
            cap_d = par_in_i;
        end else if (shift_i) begin
            cap_d = serial_i;
        end
        if (update_i) begin
            upd_d = cap_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cap_q <= 1'b0;
            upd_q <= RstVal;
        end else begin
            cap_q <= cap_d;
            upd_q <= upd_d;
        end
    end

    // Test modes hand the cell's own side to upd_q and leave the opposite side transparent.
    always_comb begin
        par_out_o = par_in_i;
        unique case (mode_i)
            ModeNormal, ModeSample: par_out_o = par_in_i;
            ModeExtest:             par_out_o = Dir ? upd_q : par_in_i;
            ModeIntest:             par_out_o = Dir ? par_in_i : upd_q;
            default:                par_out_o = par_in_i;
        endcase
    end

    assign cap_o = cap_q;

endmodule

// File: rtl/bs_register_gen2.sv
// Parametrised boundary-scan data register (capture / shift / update chain).
// Ports:
//   tck_i    test clock, all state on the rising edge
//   trst_ni  synchronous active-low reset, overrides every enable
//   bus      slave side of bs_register_gen2_if (parallel data, serial data, mode,
//            enables, shift counter and error flags)
// Parameters:
//   N           chain length (N >= 2)
//   DIR_MASK    per-bit cell type, 1 = output cell, 0 = input cell
//   RST_VAL     reset value of the update stage
//   STRICT_LEN  1: an update after a shift count other than N leaves the update stage alone
//   CW          shift counter width
// Enable priority is capture > shift > update; only the winner acts.
module bs_register_gen2
    import bs_register_gen2_pkg::*;
#(
    parameter int unsigned N          = 10,
    parameter logic [N-1:0] DIR_MASK  = {N{1'b1}},
    parameter logic [N-1:0] RST_VAL   = {N{1'b0}},
    parameter bit          STRICT_LEN = 1'b0,
    parameter int unsigned CW         = cnt_width(N)
) (
    input logic               tck_i,
    input logic               trst_ni,
    bs_register_gen2_if.slave bus
);

    logic [N-1:0]  cap;
    logic [N-1:0]  chain_in;
    logic          cap_win, shift_win, update_win, update_en;
    logic          len_ok, multi_en;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          len_err_q, len_err_d;
    logic          proto_err_q, proto_err_d;

    assign cap_win    = bus.capture_dr;
    assign shift_win  = bus.shift_dr & ~bus.capture_dr;
    assign update_win = bus.update_dr & ~bus.capture_dr & ~bus.shift_dr;
    assign len_ok     = (cnt_q == CW'(N));
    assign update_en  = update_win & (len_ok | ~STRICT_LEN);
    assign multi_en   = (bus.capture_dr & bus.shift_dr) | (bus.capture_dr & bus.update_dr) |
                        (bus.shift_dr & bus.update_dr);

    // Serial data moves towards bit 0; TDI enters at the MSB.
    assign chain_in = {bus.shift_in, cap[N-1:1]};

    for (genvar i = 0; i < int'(N); i++) begin : g_cell
        bs_register_gen2_cell #(
            .Dir    (DIR_MASK[i]),
            .RstVal (RST_VAL[i])
        ) u_cell (
            .clk_i     (tck_i),
            .rst_ni    (trst_ni),
            .capture_i (cap_win),
            .shift_i   (shift_win),
            .update_i  (update_en),
            .par_in_i  (bus.par_in[i]),
            .serial_i  (chain_in[i]),
            .mode_i    (bus.mode),
            .cap_o     (cap[i]),
            .par_out_o (bus.par_out[i])
        );
    end

    always_comb begin
        cnt_d       = cnt_q;
        len_err_d   = len_err_q;
        proto_err_d = proto_err_q | multi_en;
        if (cap_win) begin
            cnt_d = '0;
        end else if (shift_win) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (update_win) begin
            len_err_d = ~len_ok;
        end
    end

    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            cnt_q       <= '0;
            len_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            len_err_q   <= len_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.shift_out = cap[0];
    assign bus.shift_cnt = cnt_q;
    assign bus.len_err   = len_err_q;
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_bs_register_gen2.sv
// Self-checking bench for bs_register_gen2. Three instances share one stimulus stream:
//   dut_a  DIR_MASK all output cells, STRICT_LEN=0
//   dut_s  DIR_MASK all output cells, STRICT_LEN=1
//   dut_m  DIR_MASK 10'h0FF,          STRICT_LEN=0
// All use RST_VAL 10'h2A5. Directed scenarios are followed by a random phase, everything
// checked against a behavioural model of the register.
module tb_bs_register_gen2;
    import bs_register_gen2_pkg::*;

    localparam int unsigned N      = 10;
    localparam logic [9:0]  RstVal = 10'h2A5;
    localparam logic [9:0]  MaskM  = 10'h0FF;
    localparam int          CntMax = 31;

    logic  tck = 1'b0;
    logic  trst_v = 1'b1;
    logic  [9:0] par_v = '0;
    logic  si_v = 1'b0;
    mode_e mode_v = ModeNormal;
    logic  cap_v = 1'b0, sh_v = 1'b0, up_v = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model
    logic [9:0] m_cap, m_upd_a, m_upd_s;
    int         m_cnt;
    logic       m_len, m_proto;

    always #5 tck = ~tck;

    bs_register_gen2_if #(.N(N)) ifa ();
    bs_register_gen2_if #(.N(N)) ifs ();
    bs_register_gen2_if #(.N(N)) ifm ();

    assign ifa.par_in = par_v;  assign ifs.par_in = par_v;  assign ifm.par_in = par_v;
    assign ifa.shift_in = si_v; assign ifs.shift_in = si_v; assign ifm.shift_in = si_v;
    assign ifa.mode = mode_v;   assign ifs.mode = mode_v;   assign ifm.mode = mode_v;
    assign ifa.capture_dr = cap_v; assign ifs.capture_dr = cap_v; assign ifm.capture_dr = cap_v;
    assign ifa.shift_dr = sh_v;    assign ifs.shift_dr = sh_v;    assign ifm.shift_dr = sh_v;
    assign ifa.update_dr = up_v;   assign ifs.update_dr = up_v;   assign ifm.update_dr = up_v;

    bs_register_gen2 #(.N(N), .DIR_MASK(10'h3FF), .RST_VAL(RstVal), .STRICT_LEN(1'b0)) dut_a (
        .tck_i (tck), .trst_ni (trst_v), .bus (ifa)
    );
    bs_register_gen2 #(.N(N), .DIR_MASK(10'h3FF), .RST_VAL(RstVal), .STRICT_LEN(1'b1)) dut_s (
        .tck_i (tck), .trst_ni (trst_v), .bus (ifs)
    );
    bs_register_gen2 #(.N(N), .DIR_MASK(MaskM), .RST_VAL(RstVal), .STRICT_LEN(1'b0)) dut_m (
        .tck_i (tck), .trst_ni (trst_v), .bus (ifm)
    );

    function automatic logic [9:0] exp_par(input logic [9:0] upd, input logic [9:0] dir);
        case (mode_v)
            ModeExtest: return (upd & dir) | (par_v & ~dir);
            ModeIntest: return (par_v & dir) | (upd & ~dir);
            default:    return par_v;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/a.par_out"}, 32'(ifa.par_out), 32'(exp_par(m_upd_a, 10'h3FF)));
        chk({tag, "/s.par_out"}, 32'(ifs.par_out), 32'(exp_par(m_upd_s, 10'h3FF)));
        chk({tag, "/m.par_out"}, 32'(ifm.par_out), 32'(exp_par(m_upd_a, MaskM)));
        chk({tag, "/a.shift_out"}, 32'(ifa.shift_out), 32'(m_cap[0]));
        chk({tag, "/m.shift_out"}, 32'(ifm.shift_out), 32'(m_cap[0]));
        chk({tag, "/a.cnt"}, 32'(ifa.shift_cnt), 32'(m_cnt));
        chk({tag, "/s.cnt"}, 32'(ifs.shift_cnt), 32'(m_cnt));
        chk({tag, "/a.len"}, 32'(ifa.len_err), 32'(m_len));
        chk({tag, "/s.len"}, 32'(ifs.len_err), 32'(m_len));
        chk({tag, "/a.proto"}, 32'(ifa.proto_err), 32'(m_proto));
        chk({tag, "/m.proto"}, 32'(ifm.proto_err), 32'(m_proto));
    endtask

    // Applies the spec rules for one clock edge, using the inputs held across the edge.
    task automatic model_clock();
        if (!trst_v) begin
            m_cap = '0; m_upd_a = RstVal; m_upd_s = RstVal;
            m_cnt = 0; m_len = 1'b0; m_proto = 1'b0;
        end else begin
            if (int'(cap_v) + int'(sh_v) + int'(up_v) > 1) m_proto = 1'b1;
            if (cap_v) begin
                m_cap = par_v;
                m_cnt = 0;
            end else if (sh_v) begin
                m_cap = {si_v, m_cap[9:1]};
                m_cnt = (m_cnt < CntMax) ? m_cnt + 1 : CntMax;
            end else if (up_v) begin
                m_len   = (m_cnt != int'(N));
                m_upd_a = m_cap;
                if (m_cnt == int'(N)) m_upd_s = m_cap;
            end
        end
    endtask

    task automatic step(input logic c, input logic s, input logic u, input logic si,
                        input string tag);
        cap_v = c; sh_v = s; up_v = u; si_v = si;
        @(posedge tck);
        model_clock();
        #1;
        cap_v = 1'b0; sh_v = 1'b0; up_v = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        trst_v = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, tag);
        trst_v = 1'b1;
    endtask

    task automatic shift_word(input logic [9:0] v, input string tag);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, v[k], tag);
    endtask

    initial begin
        logic [9:0] pat;

        // 1: reset in EXTEST shows RST_VAL on the output cells
        mode_v = ModeExtest;
        par_v  = 10'h000;
        @(negedge tck);
        do_reset("reset");
        chk("reset/par_out", 32'(ifa.par_out), 32'h2A5);
        chk("reset/cnt", 32'(ifa.shift_cnt), 32'd0);
        chk("reset/flags", 32'({ifa.len_err, ifa.proto_err}), 32'd0);

        // 2: SAMPLE, capture 3C1 and read it out LSB first
        mode_v = ModeSample;
        par_v  = 10'h3C1;
        pat    = 10'b1111000001;
        step(1'b1, 1'b0, 1'b0, 1'b0, "sample_cap");
        for (int k = 0; k < 10; k++) begin
            chk("sample/so", 32'(ifa.shift_out), 32'(pat[k]));
            chk("sample/par_out", 32'(ifa.par_out), 32'h3C1);
            step(1'b0, 1'b1, 1'b0, 1'b0, "sample_sh");
        end

        // 3: EXTEST preload 155
        mode_v = ModeExtest;
        par_v  = 10'h0F0;
        step(1'b1, 1'b0, 1'b0, 1'b0, "ext_cap");
        shift_word(10'h155, "ext_sh");
        step(1'b0, 1'b0, 1'b1, 1'b0, "ext_upd");
        chk("extest/par_out", 32'(ifa.par_out), 32'h155);
        chk("extest/len", 32'(ifa.len_err), 32'd0);
        chk("extest/cnt", 32'(ifa.shift_cnt), 32'd10);

        // 4: short shift of 7 ones then update
        par_v = 10'h000;
        step(1'b1, 1'b0, 1'b0, 1'b0, "len_cap");
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b0, 1'b1, "len_sh");
        step(1'b0, 1'b0, 1'b1, 1'b0, "len_upd");
        chk("len/a.len", 32'(ifa.len_err), 32'd1);
        chk("len/a.par_out", 32'(ifa.par_out), 32'h3F8);
        chk("len/s.par_out", 32'(ifs.par_out), 32'h155);

        // 5: INTEST with mixed cell types
        mode_v = ModeIntest;
        step(1'b1, 1'b0, 1'b0, 1'b0, "int_cap");
        shift_word(10'h3FF, "int_sh");
        step(1'b0, 1'b0, 1'b1, 1'b0, "int_upd");
        chk("intest/m.par_out", 32'(ifm.par_out), 32'h300);

        // Mode change reaches par_out without a clock
        mode_v = ModeExtest;
        #1;
        check_all("mode_chg");
        chk("mode_chg/a.par_out", 32'(ifa.par_out), 32'h3FF);

        // 6: capture and shift together
        par_v = 10'h2D2;
        step(1'b0, 1'b1, 1'b0, 1'b1, "proto_pre");
        step(1'b1, 1'b1, 1'b0, 1'b1, "proto");
        chk("proto/cnt", 32'(ifa.shift_cnt), 32'd0);
        chk("proto/flag", 32'(ifa.proto_err), 32'd1);
        chk("proto/so", 32'(ifa.shift_out), 32'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, "proto_hold");
        chk("proto/held", 32'(ifa.proto_err), 32'd1);

        // Counter saturation
        step(1'b1, 1'b0, 1'b0, 1'b0, "sat_cap");
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), "sat");
        chk("sat/cnt", 32'(ifa.shift_cnt), 32'd31);

        // Reset in the middle of a shift
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b1, "mid_sh");
        do_reset("mid_rst");
        chk("mid_rst/par_out", 32'(ifa.par_out), 32'h2A5);
        chk("mid_rst/cnt", 32'(ifa.shift_cnt), 32'd0);
        chk("mid_rst/proto", 32'(ifa.proto_err), 32'd0);

        // Random phase; enables mostly single, occasional collisions and resets
        for (int k = 0; k < 300; k++) begin
            int r;
            logic c, s, u;
            r = int'($urandom_range(0, 99));
            c = (r < 8);
            s = (r >= 8 && r < 70);
            u = (r >= 70 && r < 82);
            if (r >= 97) begin
                c = 1'($urandom_range(0, 1));
                s = 1'b1;
                u = 1'($urandom_range(0, 1));
            end
            par_v  = 10'($urandom);
            mode_v = mode_e'($urandom_range(0, 3));
            trst_v = ($urandom_range(0, 63) != 0);
            step(c, s, u, 1'($urandom_range(0, 1)), "rand");
            trst_v = 1'b1;
            if (r % 5 == 0) begin
                mode_v = mode_e'($urandom_range(0, 3));
                par_v  = 10'($urandom);
                #1;
                check_all("rand_mode");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
